// File: rtl/uart_program_loader_pkg.sv
// Shared definitions for the UART program loader: FSM encodings, the default
// frame sync marker and the CPU vector table addresses.
package uart_program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_H,
        ST_LEN_L,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } loader_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    localparam logic [9:0] VEC_RESET = 10'h000;
    localparam logic [9:0] VEC_IRQ0  = 10'h010;
    localparam logic [9:0] VEC_IRQ1  = 10'h020;
    localparam logic [9:0] VEC_IRQ2  = 10'h030;

    function automatic logic is_busy_state(input loader_state_e s);
        return (s == ST_LEN_H) || (s == ST_LEN_L) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

    function automatic logic is_vector_addr(input logic [9:0] a);
        return (a == VEC_RESET) || (a == VEC_IRQ0) || (a == VEC_IRQ1) || (a == VEC_IRQ2);
    endfunction

endpackage

// File: rtl/uart_program_loader_uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchronizer, false-start rejection
// and single-cycle byte_valid / frame_err pulses.
module uart_rx
    import uart_program_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_out_q, byte_out_d;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_err_q, frame_err_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_out_d   = byte_out_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                // Mid-bit recheck: a line already back high was only a glitch.
                if (cnt_q == HALF_LAST) begin
                    if (rx_sync_q) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d   = RX_DATA;
                        cnt_d     = '0;
                        bit_idx_d = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    state_d = RX_IDLE;
                    if (rx_sync_q) begin
                        byte_valid_d = 1'b1;
                        byte_out_d   = shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            state_q      <= RX_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            byte_out_q   <= 8'h00;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_meta_q    <= rx;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: rtl/uart_program_loader.sv
// Loads a program image from UART into program memory and holds the CPU in reset
// until a valid image is present. Define LOADER_CHECKSUM_EN to require a trailing checksum byte.
module uart_program_loader
    import uart_program_loader_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 434,
    parameter int         MEM_DEPTH    = 1024,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
    parameter int         BOOT_TIMEOUT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic [9:0] addr_bus,
    output logic [7:0] data_bus,
    output logic       cpu_rst,
    output logic       load_busy,
    output logic       load_error
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [7:0] rx_byte;
    logic       rx_byte_valid;
    logic       rx_frame_err;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .byte_out  (rx_byte),
        .byte_valid(rx_byte_valid),
        .frame_err (rx_frame_err)
    );

    logic [7:0] mem [MEM_DEPTH];

    loader_state_e state_q, state_d;
    logic [9:0]    wr_addr_q, wr_addr_d;
    logic [9:0]    len_q, len_d;
    logic [7:0]    csum_q, csum_d;
    logic [31:0]   timeout_cnt_q, timeout_cnt_d;
    logic          first_idle_q, first_idle_d;
    logic          cpu_rst_q, cpu_rst_d;
    logic          load_busy_q, load_busy_d;
    logic          load_error_q, load_error_d;
    logic          mem_we;

    always_comb begin
        state_d       = state_q;
        wr_addr_d     = wr_addr_q;
        len_d         = len_q;
        csum_d        = csum_q;
        timeout_cnt_d = timeout_cnt_q;
        first_idle_d  = first_idle_q;
        mem_we        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_byte_valid) begin
                    first_idle_d = 1'b0;
                    if (rx_byte == SYNC_BYTE) state_d = ST_LEN_H;
                end else if (BOOT_TIMEOUT != 0 && first_idle_q) begin
                    if (timeout_cnt_q == 32'(BOOT_TIMEOUT - 1)) begin
                        state_d      = ST_DONE;
                        first_idle_d = 1'b0;
                    end else begin
                        timeout_cnt_d = timeout_cnt_q + 32'd1;
                    end
                end
            end
            ST_LEN_H: begin
                if (rx_byte_valid) begin
                    if (|rx_byte[7:2]) begin
                        state_d = ST_ERROR;
                    end else begin
                        len_d[9:8] = rx_byte[1:0];
                        state_d    = ST_LEN_L;
                    end
                end
            end
            ST_LEN_L: begin
                if (rx_byte_valid) begin
                    len_d[7:0] = rx_byte;
                    wr_addr_d  = 10'd0;
                    csum_d     = 8'h00;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_byte_valid) begin
                    mem_we    = !rst && ({22'd0, wr_addr_q} < 32'(MEM_DEPTH));
                    wr_addr_d = wr_addr_q + 10'd1;
                    csum_d    = csum_q + rx_byte;
                    // len_q holds N-1, so matching it marks the final data byte.
                    if (wr_addr_q == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (rx_byte_valid) begin
                    state_d = (rx_byte == csum_q) ? ST_DONE : ST_ERROR;
                end
            end
`endif
            ST_DONE, ST_ERROR: begin
                if (rx_byte_valid && rx_byte == SYNC_BYTE) state_d = ST_LEN_H;
            end
            default: ;
        endcase
        if (rx_frame_err && state_q != ST_IDLE && state_q != ST_DONE) begin
            state_d = ST_ERROR;
        end
    end

    // Outputs are registered; cpu_rst follows the state one cycle late.
    always_comb begin
        cpu_rst_d    = (state_q != ST_DONE);
        load_busy_d  = is_busy_state(state_d);
        load_error_d = load_error_q;
        if (state_d == ST_ERROR) begin
            load_error_d = 1'b1;
        end else if (state_d == ST_DONE && state_q != ST_DONE) begin
            load_error_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            wr_addr_q     <= 10'd0;
            len_q         <= 10'd0;
            csum_q        <= 8'h00;
            timeout_cnt_q <= 32'd0;
            first_idle_q  <= 1'b1;
            cpu_rst_q     <= 1'b1;
            load_busy_q   <= 1'b0;
            load_error_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_addr_q     <= wr_addr_d;
            len_q         <= len_d;
            csum_q        <= csum_d;
            timeout_cnt_q <= timeout_cnt_d;
            first_idle_q  <= first_idle_d;
            cpu_rst_q     <= cpu_rst_d;
            load_busy_q   <= load_busy_d;
            load_error_q  <= load_error_d;
        end
    end

    // Memory is deliberately outside reset so an image survives a CPU reboot.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_addr_q[AW-1:0]] <= rx_byte;
    end

    always_comb begin
        data_bus = 8'h00;
        if ({22'd0, addr_bus} < 32'(MEM_DEPTH)) data_bus = mem[addr_bus[AW-1:0]];
    end

    assign cpu_rst    = cpu_rst_q | rst;
    assign load_busy  = load_busy_q;
    assign load_error = load_error_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: frame loads, checksum errors, bad length,
// glitch rejection, framing error, mid-frame reset and boot timeout.
module tb_uart_program_loader;

    localparam int CPB = 4;

`ifdef LOADER_CHECKSUM_EN
    localparam logic CSUM_EN = 1'b1;
`else
    localparam logic CSUM_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, rx, rst2, rx2;
    logic [9:0] addr_bus, addr2;
    logic [7:0] data_bus, data2;
    logic       cpu_rst, load_busy, load_error;
    logic       cpu_rst2, load_busy2, load_error2;

    int total = 0;
    int bad   = 0;
    int rx_bytes = 0;

    uart_program_loader #(
        .CLKS_PER_BIT(CPB),
        .BOOT_TIMEOUT(0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .addr_bus  (addr_bus),
        .data_bus  (data_bus),
        .cpu_rst   (cpu_rst),
        .load_busy (load_busy),
        .load_error(load_error)
    );

    uart_program_loader #(
        .CLKS_PER_BIT(CPB),
        .MEM_DEPTH   (512),
        .BOOT_TIMEOUT(20)
    ) dut_to (
        .clk       (clk),
        .rst       (rst2),
        .rx        (rx2),
        .addr_bus  (addr2),
        .data_bus  (data2),
        .cpu_rst   (cpu_rst2),
        .load_busy (load_busy2),
        .load_error(load_error2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dut.rx_byte_valid) rx_bytes <= rx_bytes + 1;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one 8N1 character followed by two idle bit times.
    task automatic apply_stimulus(input logic sel, input logic [7:0] b, input logic stop_bit);
        if (sel) rx2 = 1'b0; else rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (sel) rx2 = b[i]; else rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        if (sel) rx2 = stop_bit; else rx = stop_bit;
        repeat (CPB) @(negedge clk);
        if (sel) rx2 = 1'b1; else rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic send_bytes(input logic sel, input logic [7:0] bytes[$]);
        foreach (bytes[i]) apply_stimulus(sel, bytes[i], 1'b1);
    endtask

    task automatic check_mem(input string tag, input logic [9:0] a, input logic [7:0] exp);
        addr_bus = a;
        #1;
        check_output(tag, {24'd0, data_bus}, {24'd0, exp});
    endtask

    initial begin
        rst = 1'b1; rx = 1'b1; rst2 = 1'b1; rx2 = 1'b1;
        addr_bus = 10'd0; addr2 = 10'd0;
        repeat (3) @(negedge clk);
        check_output("reset_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check_output("reset_busy", {31'd0, load_busy}, 32'd0);
        check_output("reset_error", {31'd0, load_error}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_output("idle_no_timeout_cpu_rst", {31'd0, cpu_rst}, 32'd1);

        $display("[TB] test 1: three-byte image");
        apply_stimulus(1'b0, 8'hA5, 1'b1);
        check_output("t1_busy_after_sync", {31'd0, load_busy}, 32'd1);
        send_bytes(1'b0, '{8'h00, 8'h02, 8'h81, 8'h05, 8'h10});
        check_output("t1_cpu_rst_before_csum", {31'd0, cpu_rst}, {31'd0, CSUM_EN});
        apply_stimulus(1'b0, 8'h96, 1'b1);
        check_output("t1_cpu_rst_released", {31'd0, cpu_rst}, 32'd0);
        check_output("t1_busy_done", {31'd0, load_busy}, 32'd0);
        check_output("t1_error", {31'd0, load_error}, 32'd0);
        check_mem("t1_mem0", 10'd0, 8'h81);
        check_mem("t1_mem1", 10'd1, 8'h05);
        check_mem("t1_mem2", 10'd2, 8'h10);

        $display("[TB] test 2: checksum mismatch then retry");
        send_bytes(1'b0, '{8'hA5, 8'h00, 8'h00, 8'h3D, 8'h00});
        check_output("t2_bad_csum_error", {31'd0, load_error}, {31'd0, CSUM_EN});
        check_output("t2_bad_csum_cpu_rst", {31'd0, cpu_rst}, {31'd0, CSUM_EN});
        send_bytes(1'b0, '{8'hA5, 8'h00, 8'h00, 8'h3D, 8'h3D});
        check_output("t2_retry_error", {31'd0, load_error}, 32'd0);
        check_output("t2_retry_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        check_mem("t2_mem0", 10'd0, 8'h3D);
        check_mem("t2_mem1_kept", 10'd1, 8'h05);
        check_mem("t2_mem2_kept", 10'd2, 8'h10);

        $display("[TB] test 3: oversized length high byte");
        send_bytes(1'b0, '{8'hA5, 8'h04, 8'h00});
        check_output("t3_error", {31'd0, load_error}, 32'd1);
        check_output("t3_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check_output("t3_busy", {31'd0, load_busy}, 32'd0);

        $display("[TB] test 4: rx glitch rejection");
        rx_bytes = 0;
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (50) @(negedge clk);
        check_output("t4_glitch_bytes", rx_bytes, 32'd0);
        send_bytes(1'b0, '{8'hA5, 8'h00, 8'h00, 8'h07, 8'h07});
        check_output("t4_frame_bytes", rx_bytes, 32'd5);
        check_output("t4_error", {31'd0, load_error}, 32'd0);
        check_output("t4_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        check_mem("t4_mem0", 10'd0, 8'h07);

        $display("[TB] test 5: framing error and mid-frame reset");
        rst = 1'b1;
        #1;
        check_output("t5_rst_same_cycle", {31'd0, cpu_rst}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_bytes(1'b0, '{8'hA5, 8'h00, 8'h02, 8'h11});
        apply_stimulus(1'b0, 8'h22, 1'b0);
        check_output("t5_ferr_error", {31'd0, load_error}, 32'd1);
        check_output("t5_ferr_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check_mem("t5_mem1_not_written", 10'd1, 8'h05);
        send_bytes(1'b0, '{8'hA5, 8'h00, 8'h05, 8'h01});
        check_output("t5_busy_mid_frame", {31'd0, load_busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_output("t5_busy_after_rst", {31'd0, load_busy}, 32'd0);
        check_output("t5_error_after_rst", {31'd0, load_error}, 32'd0);
        check_output("t5_cpu_rst_after_rst", {31'd0, cpu_rst}, 32'd1);
        check_mem("t5_partial_mem0", 10'd0, 8'h01);

        $display("[TB] test 6: boot timeout");
        check_output("t6_reset_cpu_rst", {31'd0, cpu_rst2}, 32'd1);
        rst2 = 1'b0;
        repeat (20) @(negedge clk);
        check_output("t6_cycle20_cpu_rst", {31'd0, cpu_rst2}, 32'd1);
        @(negedge clk);
        check_output("t6_cycle21_cpu_rst", {31'd0, cpu_rst2}, 32'd0);
        apply_stimulus(1'b1, 8'hA5, 1'b1);
        check_output("t6_reload_cpu_rst", {31'd0, cpu_rst2}, 32'd1);
        check_output("t6_reload_busy", {31'd0, load_busy2}, 32'd1);
        send_bytes(1'b1, '{8'h00, 8'h00, 8'h42, 8'h42});
        check_output("t6_done_cpu_rst", {31'd0, cpu_rst2}, 32'd0);
        check_output("t6_done_error", {31'd0, load_error2}, 32'd0);
        addr2 = 10'd0;
        #1;
        check_output("t6_mem0", {24'd0, data2}, 32'h42);
        addr2 = 10'h200;
        #1;
        check_output("t6_out_of_range", {24'd0, data2}, 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
